// File: rtl/sbox_seq_ctrl.sv
// Shares one DES S-box lookup port across all eight boxes: a 48-bit keyed word
// is walked out one 6-bit chunk per cycle and the 4-bit answers are gathered.
module sbox_seq_ctrl #(
  parameter int SB_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic [2:0]  sb_sel,
  output logic [5:0]  sb_addr,
  output logic        sb_req,
  input  logic [3:0]  sb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [47:0] shadow_reg;
  logic [2:0]  issue_cnt_reg;
  logic        issue_done_reg;
  logic [2:0]  cap_cnt_reg;
  logic [5:0]  chunk [8];
  logic        accept;
  logic        capture;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (capture && (cap_cnt_reg == 3'd7)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    sb_req    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      LOOKUP:  sb_req    = !issue_done_reg;
      DONE:    out_valid = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  // Shadow copy lets the producer move on once the word has been accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg <= 48'h0;
    end else if (accept) begin
      shadow_reg <= in_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_chunk
      assign chunk[gi] = shadow_reg[47-6*gi -: 6];
    end
  endgenerate

  assign sb_sel  = issue_cnt_reg;
  assign sb_addr = chunk[issue_cnt_reg];

  // Counter parks at 7 with a done flag so sb_sel/sb_addr keep their last values.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      issue_cnt_reg  <= 3'd0;
      issue_done_reg <= 1'b0;
    end else if (sb_req) begin
      if (issue_cnt_reg == 3'd7) begin
        issue_done_reg <= 1'b1;
      end else begin
        issue_cnt_reg <= issue_cnt_reg + 3'd1;
      end
    end
  end

  generate
    if (SB_LAT == 0) begin : g_comb_bank
      assign capture = sb_req;
    end else begin : g_reg_bank
      logic cap_pend_reg;

      // Cleared on reset so an abandoned lookup is never captured.
      always_ff @(posedge clk) begin
        if (rst) begin
          cap_pend_reg <= 1'b0;
        end else begin
          cap_pend_reg <= sb_req;
        end
      end

      assign capture = cap_pend_reg && (state_reg == LOOKUP);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      cap_cnt_reg <= 3'd0;
    end else if (capture && (cap_cnt_reg != 3'd7)) begin
      cap_cnt_reg <= cap_cnt_reg + 3'd1;
    end
  end

  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      logic [3:0] nib_reg;

      always_ff @(posedge clk) begin
        if (rst || accept) begin
          nib_reg <= 4'h0;
        end else if (capture && (cap_cnt_reg == 3'(gi))) begin
          nib_reg <= sb_data;
        end
      end

      assign out_data[31-4*gi -: 4] = nib_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sbox_seq_ctrl.sv
// Bench for sbox_seq_ctrl: one instance per bank latency, each fed by a DES
// S-box bank model and checked against a whole-word reference model.
module tb_sbox_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst       = 2'b11;
  logic [1:0]  in_valid  = 2'b00;
  logic [1:0]  out_ready = 2'b00;
  logic [47:0] in_data [2] = '{48'h0, 48'h0};
  wire  [1:0]  in_ready;
  wire  [1:0]  sb_req;
  wire  [1:0]  out_valid;
  wire  [1:0]  busy;
  wire  [2:0]  sb_sel   [2];
  wire  [5:0]  sb_addr  [2];
  wire  [31:0] out_data [2];
  logic [3:0]  noise = 4'h0;

  int checks = 0;
  int errors = 0;

  // DES S1..S8, row-major: index = box*64 + row*16 + col
  int sb_tab [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
     0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
    15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
     3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
    13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
     1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
    13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
     3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
    14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
    11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
    10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
     4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
    13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
     6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
     1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
     2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
  };

  function automatic logic [3:0] sbox_f(input int box, input logic [5:0] a);
    int idx;
    idx = box * 64 + int'({a[5], a[0]}) * 16 + int'(a[4:1]);
    return 4'(sb_tab[idx]);
  endfunction

  function automatic logic [31:0] model(input logic [47:0] w);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 8; b++) begin
      r = {r[27:0], sbox_f(b, w[47-6*b -: 6])};
    end
    return r;
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", tag, got, want, $time);
    end
  endtask

  always @(posedge clk) noise <= 4'($urandom());

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      logic [3:0] sb_data;

      if (gi == 0) begin : g_bank
        always_comb sb_data = sb_req[gi] ? sbox_f(int'(sb_sel[gi]), sb_addr[gi]) : noise;
      end else begin : g_bank
        always @(posedge clk) sb_data <= sb_req[gi] ? sbox_f(int'(sb_sel[gi]), sb_addr[gi]) : noise;
      end

      sbox_seq_ctrl #(.SB_LAT(gi)) u_dut (
        .clk       (clk),
        .rst       (rst[gi]),
        .in_valid  (in_valid[gi]),
        .in_ready  (in_ready[gi]),
        .in_data   (in_data[gi]),
        .sb_sel    (sb_sel[gi]),
        .sb_addr   (sb_addr[gi]),
        .sb_req    (sb_req[gi]),
        .sb_data   (sb_data),
        .out_valid (out_valid[gi]),
        .out_ready (out_ready[gi]),
        .out_data  (out_data[gi]),
        .busy      (busy[gi])
      );
    end
  endgenerate

  // Scoreboard state, sampled on the falling edge
  bit          in_flight  [2] = '{1'b0, 1'b0};
  int          cyc        [2] = '{0, 0};
  int          words_done [2] = '{0, 0};
  logic [47:0] word       [2];
  logic [31:0] exp_res    [2];

  task automatic monitor_step(input int d);
    int lat;
    lat = 9 + d;
    if (rst[d]) begin
      in_flight[d] = 1'b0;
    end else begin
      chk("busy", 64'(busy[d]), 64'(in_flight[d]));
      chk("in_ready", 64'(in_ready[d]), 64'(!in_flight[d]));
      if (in_flight[d]) begin
        cyc[d]++;
        chk("sb_req", 64'(sb_req[d]), 64'(cyc[d] <= 8));
        if (sb_req[d] && cyc[d] <= 8) begin
          chk("sb_sel", 64'(sb_sel[d]), 64'(cyc[d] - 1));
          chk("sb_addr", 64'(sb_addr[d]), 64'(word[d][47-6*(cyc[d]-1) -: 6]));
        end
        chk("out_valid_timing", 64'(out_valid[d]), 64'(cyc[d] >= lat));
        if (out_valid[d]) begin
          chk("out_data", 64'(out_data[d]), 64'(exp_res[d]));
          if (out_ready[d]) begin
            $display("dut%0d word %012h result %08h expected %08h", d, word[d], out_data[d], exp_res[d]);
            in_flight[d] = 1'b0;
            words_done[d]++;
          end
        end
      end else begin
        chk("idle_sb_req", 64'(sb_req[d]), 64'(0));
        chk("idle_out_valid", 64'(out_valid[d]), 64'(0));
        if (in_valid[d] && in_ready[d]) begin
          in_flight[d] = 1'b1;
          cyc[d]       = 0;
          word[d]      = in_data[d];
          exp_res[d]   = model(in_data[d]);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    monitor_step(0);
    monitor_step(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [47:0] w);
    int n;
    n = 0;
    in_valid[d] = 1'b1;
    in_data[d]  = w;
    while (!in_ready[d] && n < 100) begin
      tick();
      n++;
    end
    chk("send_timeout", 64'(n < 100), 64'(1));
    tick();
    in_valid[d] = 1'b0;
    in_data[d]  = rnd48();
  endtask

  task automatic recv(input int d, input int delay, output logic [31:0] r);
    int n;
    n = 0;
    out_ready[d] = 1'b0;
    repeat (delay) tick();
    out_ready[d] = 1'b1;
    while (!out_valid[d] && n < 100) begin
      tick();
      n++;
    end
    chk("recv_timeout", 64'(n < 100), 64'(1));
    r = out_data[d];
    tick();
    out_ready[d] = 1'b0;
  endtask

  task automatic run_seq(input int d);
    logic [31:0] r;
    logic [31:0] held;
    logic [47:0] w1;
    logic [47:0] w2;
    int          n;
    int          sent_ok;
    int          nacc;
    int          t;
    int          last;
    sent_ok = 0;

    rst[d] = 1'b1;
    tick();
    tick();
    rst[d] = 1'b0;
    chk("rst_in_ready", 64'(in_ready[d]), 64'(1));
    chk("rst_out_valid", 64'(out_valid[d]), 64'(0));
    chk("rst_sb_req", 64'(sb_req[d]), 64'(0));
    chk("rst_busy", 64'(busy[d]), 64'(0));
    chk("rst_sb_sel", 64'(sb_sel[d]), 64'(0));
    chk("rst_sb_addr", 64'(sb_addr[d]), 64'(0));
    chk("rst_out_data", 64'(out_data[d]), 64'(0));

    send(d, 48'h0);
    recv(d, 0, r);
    chk("vec_zero", 64'(r), 64'(32'hEFA72C4D));
    send(d, 48'hFFFF_FFFF_FFFF);
    recv(d, 0, r);
    chk("vec_ones", 64'(r), 64'(32'hD9CE3DCB));
    send(d, 48'h0000_0004_0000);
    recv(d, 0, r);
    chk("vec_s5", 64'(r), 64'(32'hEFA7EC4D));
    sent_ok += 3;

    // Output back-pressure with a second word waiting at the input
    w1 = rnd48();
    w2 = rnd48();
    send(d, w1);
    out_ready[d] = 1'b0;
    n = 0;
    while (!out_valid[d] && n < 100) begin
      tick();
      n++;
    end
    chk("hold_wait", 64'(n < 100), 64'(1));
    held        = out_data[d];
    in_valid[d] = 1'b1;
    in_data[d]  = w2;
    chk("hold_first", 64'(held), 64'(model(w1)));
    repeat (20) begin
      tick();
      chk("hold_valid", 64'(out_valid[d]), 64'(1));
      chk("hold_data", 64'(out_data[d]), 64'(held));
      chk("hold_in_ready", 64'(in_ready[d]), 64'(0));
    end
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    chk("reaccept_ready", 64'(in_ready[d]), 64'(1));
    tick();
    in_valid[d] = 1'b0;
    chk("reaccept_busy", 64'(in_ready[d]), 64'(0));
    recv(d, 0, r);
    chk("hold_second", 64'(r), 64'(model(w2)));
    sent_ok += 2;

    // Reset while the fifth lookup (i=4) is on the port
    send(d, rnd48());
    repeat (4) tick();
    chk("pre_rst_sel", 64'(sb_sel[d]), 64'(4));
    rst[d] = 1'b1;
    tick();
    rst[d] = 1'b0;
    chk("mid_rst_in_ready", 64'(in_ready[d]), 64'(1));
    chk("mid_rst_sb_req", 64'(sb_req[d]), 64'(0));
    chk("mid_rst_out_valid", 64'(out_valid[d]), 64'(0));
    chk("mid_rst_busy", 64'(busy[d]), 64'(0));
    send(d, 48'h0);
    recv(d, 0, r);
    chk("post_rst_zero", 64'(r), 64'(32'hEFA72C4D));
    sent_ok += 1;

    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      w1 = rnd48();
      send(d, w1);
      recv(d, int'($urandom_range(0, 4)), r);
      chk("rand_word", 64'(r), 64'(model(w1)));
      sent_ok++;
    end

    // Back-to-back: in_valid held high, out_ready held high
    in_valid[d]  = 1'b1;
    in_data[d]   = rnd48();
    out_ready[d] = 1'b1;
    nacc = 0;
    t    = 0;
    last = 0;
    while (nacc < 6 && t < 200) begin
      if (in_ready[d]) begin
        if (nacc > 0) begin
          chk("b2b_period", 64'(t - last), 64'(10 + d));
        end
        last = t;
        nacc++;
        tick();
        in_data[d] = rnd48();
      end else begin
        tick();
      end
      t++;
    end
    chk("b2b_accepts", 64'(nacc), 64'(6));
    in_valid[d] = 1'b0;
    n = 0;
    while (in_flight[d] && n < 100) begin
      tick();
      n++;
    end
    chk("b2b_drain", 64'(in_flight[d]), 64'(0));
    out_ready[d] = 1'b0;
    sent_ok += nacc;
    tick();
    chk("word_count", 64'(words_done[d]), 64'(sent_ok));
  endtask

  initial begin
    tick();
    run_seq(0);
    run_seq(1);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
